vertex_mem_slave: RTL

VERTEX_MEM_SLAVE -- requirements
Module: vertex_mem_slave

---
 rtl/gpu_axi_pkg.sv | 11 +
 rtl/axil_addr_decode.sv | 18 +
 rtl/vertex_mem_slave.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gpu_axi_pkg.sv
// Shared AXI4-Lite response codes and channel FSM states for the vertex memory slave and fetch master.
// No logic, types and constants only.
package gpu_axi_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {R_IDLE, R_DATA} rd_state_t;
   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
endpackage

// File: rtl/axil_addr_decode.sv
// Byte address to word index plus in-range flag; purely combinational, zero latency, no backpressure.
module axil_addr_decode #(
   parameter int                     MADDR_WIDTH = 32,
   parameter int                     DEPTH       = 32,
   parameter logic [MADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                     IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic [MADDR_WIDTH-1:0] addr,
   output logic [IDX_W-1:0]       index,
   output logic                   in_range
);
   logic [MADDR_WIDTH-1:0] word;

   // Subtraction wraps for addr < BASE_ADDR, so the explicit compare guards that case.
   assign word     = (addr - BASE_ADDR) >> 2;
   assign in_range = (addr >= BASE_ADDR) && (word < MADDR_WIDTH'(DEPTH));
   assign index    = word[IDX_W-1:0];
endmodule

// File: rtl/vertex_mem_slave.sv
// AXI4-Lite word memory for vertex/colour fetch; read data 1 cycle after AR, B 1 cycle after AW+W commit.
// Each channel holds its response until taken; AR/AW/W ready drop while a response is pending.
module vertex_mem_slave
   import gpu_axi_pkg::*;
#(
   parameter int                     MADDR_WIDTH = 32,
   parameter int                     DEPTH       = 32,
   parameter logic [MADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_lock,
   input  logic [MADDR_WIDTH-1:0] awaddr_s,
   input  logic [2:0]             awprot_s,
   input  logic                   awvalid_s,
   output logic                   awready_s,
   input  logic [31:0]            wdata_s,
   input  logic [3:0]             wstrb_s,
   input  logic                   wvalid_s,
   output logic                   wready_s,
   output logic [1:0]             bresp_s,
   output logic                   bvalid_s,
   input  logic                   bready_s,
   input  logic [MADDR_WIDTH-1:0] araddr_s,
   input  logic [2:0]             arprot_s,
   input  logic                   arvalid_s,
   output logic                   arready_s,
   output logic [31:0]            rdata_s,
   output logic [1:0]             rresp_s,
   output logic                   rvalid_s,
   input  logic                   rready_s
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]            mem [DEPTH];
   rd_state_t              r_state;
   wr_state_t              w_state;
   logic                   aw_got, w_got;
   logic [MADDR_WIDTH-1:0] aw_addr_q;
   logic [31:0]            w_data_q;
   logic [3:0]             w_strb_q;

   logic                   aw_fire, w_fire, commit;
   logic [MADDR_WIDTH-1:0] wr_addr;
   logic [31:0]            wr_data;
   logic [3:0]             wr_strb;
   logic [IDX_W-1:0]       rd_idx, wr_idx;
   logic                   rd_in_range, wr_in_range;
   logic                   unused_prot;

   assign unused_prot = ^{awprot_s, arprot_s};

   assign arready_s = (r_state == R_IDLE);
   assign awready_s = (w_state == W_IDLE) && !aw_got;
   assign wready_s  = (w_state == W_IDLE) && !w_got;

   assign aw_fire = awvalid_s && awready_s;
   assign w_fire  = wvalid_s && wready_s;
   // Second half of the pair may arrive this cycle, so merge latched and live values.
   assign commit  = (aw_got || aw_fire) && (w_got || w_fire);
   assign wr_addr = aw_got ? aw_addr_q : awaddr_s;
   assign wr_data = w_got ? w_data_q : wdata_s;
   assign wr_strb = w_got ? w_strb_q : wstrb_s;

   axil_addr_decode #(
      .MADDR_WIDTH(MADDR_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
   ) u_ar_decode (
      .addr(araddr_s), .index(rd_idx), .in_range(rd_in_range)
   );

   axil_addr_decode #(
      .MADDR_WIDTH(MADDR_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
   ) u_aw_decode (
      .addr(wr_addr), .index(wr_idx), .in_range(wr_in_range)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= R_IDLE;
         rvalid_s <= 1'b0;
         rdata_s  <= '0;
         rresp_s  <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: if (arvalid_s) begin
               rdata_s  <= rd_in_range ? mem[rd_idx] : '0;
               rresp_s  <= rd_in_range ? RESP_OKAY : RESP_DECERR;
               rvalid_s <= 1'b1;
               r_state  <= R_DATA;
            end
            R_DATA: if (rready_s) begin
               rvalid_s <= 1'b0;
               r_state  <= R_IDLE;
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_state   <= W_IDLE;
         aw_got    <= 1'b0;
         w_got     <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_s  <= 1'b0;
         bresp_s   <= RESP_OKAY;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         case (w_state)
            W_IDLE: if (commit) begin
               if (wr_in_range && !wr_lock) begin
                  for (int b = 0; b < 4; b++)
                     if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
               end
               bresp_s  <= !wr_in_range ? RESP_DECERR : (wr_lock ? RESP_SLVERR : RESP_OKAY);
               aw_got   <= 1'b0;
               w_got    <= 1'b0;
               bvalid_s <= 1'b1;
               w_state  <= W_RESP;
            end else begin
               if (aw_fire) begin
                  aw_got    <= 1'b1;
                  aw_addr_q <= awaddr_s;
               end
               if (w_fire) begin
                  w_got    <= 1'b1;
                  w_data_q <= wdata_s;
                  w_strb_q <= wstrb_s;
               end
            end
            W_RESP: if (bready_s) begin
               bvalid_s <= 1'b0;
               w_state  <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end
endmodule
